// File: rtl/uart_bus_sequencer.sv
// uart_bus_sequencer: autonomous bus master for the uart_top register port.
// Moves bytes between a host-side TX FIFO / RX FIFO and the UART's SEND/RECV
// registers. It polls STATUS (bit0 = tx ready, bit1 = rx available), so the
// CPU never has to spin on the UART itself.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | nothing to do this cycle; bus quiet
//  POLL  | read STATUS (0xC); rdata picks RECV, SEND or IDLE
//  RECV  | read RECV (0x4); low byte goes into the RX FIFO
//  RXACK | write 32'h2 to STATUS to clear the rx-available flag
//  SEND  | write TX head to SEND (0x8); TX FIFO pops
//  WAIT  | bus quiet for POST_SEND_WAIT cycles so STATUS catches up
module uart_bus_sequencer #(
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8,
    parameter int POST_SEND_WAIT = 8,
    parameter int RX_ACK_WRITE   = 1
) (
    input  logic                        clk_bus,
    input  logic                        rst_n,
    input  logic                        tx_valid,
    input  logic [7:0]                  tx_data,
    output logic                        tx_ready,
    output logic                        rx_valid,
    output logic [7:0]                  rx_data,
    input  logic                        rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        busy,
    output logic [3:0]                  uart_addr,
    output logic [31:0]                 uart_wdata,
    output logic                        uart_rd,
    output logic                        uart_wr,
    input  logic [31:0]                 uart_rdata
);

    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam logic [TXA:0] TX_FULL = TX_DEPTH[TXA:0];
    localparam logic [RXA:0] RX_FULL = RX_DEPTH[RXA:0];
    // The counter is loaded with POST_SEND_WAIT-1 so WAIT lasts exactly POST_SEND_WAIT cycles.
    localparam int WW = (POST_SEND_WAIT > 2) ? $clog2(POST_SEND_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'((POST_SEND_WAIT > 0) ? POST_SEND_WAIT - 1 : 0);

    localparam logic [3:0] ADDR_RECV   = 4'h4;
    localparam logic [3:0] ADDR_SEND   = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_RECV,
        S_RXACK,
        S_SEND,
        S_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]    r_tx_mem [TX_DEPTH];
    logic [TXA-1:0] r_tx_rd;
    logic [TXA-1:0] r_tx_wr;
    logic [TXA:0]  r_tx_cnt;

    logic [7:0]    r_rx_mem [RX_DEPTH];
    logic [RXA-1:0] r_rx_rd;
    logic [RXA-1:0] r_rx_wr;
    logic [RXA:0]  r_rx_cnt;

    logic [WW-1:0] r_wait_cnt;

    logic        w_tx_full;
    logic        w_tx_nonempty;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_full;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_bus_rd;
    logic        w_bus_wr;
    logic [3:0]  w_bus_addr;
    logic [31:0] w_bus_wdata;
    logic        w_unused_rdata;

    assign w_unused_rdata = ^uart_rdata[31:8];

    assign w_tx_full     = (r_tx_cnt == TX_FULL);
    assign w_tx_nonempty = (r_tx_cnt != '0);
    assign w_tx_push     = tx_valid && !w_tx_full;
    assign w_tx_pop      = (r_state == S_SEND) && w_tx_nonempty;

    assign w_rx_full = (r_rx_cnt == RX_FULL);
    assign w_rx_push = (r_state == S_RECV) && !w_rx_full;
    assign w_rx_pop  = rx_valid && rx_ready;

    assign tx_ready = !w_tx_full;
    assign tx_level = r_tx_cnt;
    assign rx_valid = (r_rx_cnt != '0);
    assign rx_level = r_rx_cnt;
    // Gate the head so rx_data reads zero while empty, including after reset.
    assign rx_data  = rx_valid ? r_rx_mem[r_rx_rd] : 8'h00;
    assign busy     = (r_state != S_IDLE);

    // TX FIFO storage: written on every accepted host push.
    always_ff @(posedge clk_bus) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= tx_data;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO storage: captures the RECV byte at the edge ending the read.
    always_ff @(posedge clk_bus) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= uart_rdata[7:0];
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_rx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Post-send hold-off down-counter.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_SEND) begin
            r_wait_cnt <= WAIT_LOAD;
        end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; RX service wins over TX in POLL.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Counting an incoming push lets the first byte reach POLL one cycle sooner.
                if (w_tx_nonempty || w_tx_push || !w_rx_full) w_next = S_POLL;
            end
            S_POLL: begin
                if (uart_rdata[1] && !w_rx_full)         w_next = S_RECV;
                else if (uart_rdata[0] && w_tx_nonempty) w_next = S_SEND;
                else                                     w_next = S_IDLE;
            end
            S_RECV:  w_next = (RX_ACK_WRITE != 0) ? S_RXACK : S_POLL;
            S_RXACK: w_next = S_POLL;
            S_SEND:  w_next = (POST_SEND_WAIT == 0) ? S_POLL : S_WAIT;
            S_WAIT: begin
                if (r_wait_cnt == '0) w_next = S_POLL;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bus request for the state being entered, so the registered outputs match r_state.
    always_comb begin
        w_bus_rd    = 1'b0;
        w_bus_wr    = 1'b0;
        w_bus_addr  = ADDR_STATUS;
        w_bus_wdata = 32'h0;
        case (w_next)
            S_POLL: w_bus_rd = 1'b1;
            S_RECV: begin
                w_bus_rd   = 1'b1;
                w_bus_addr = ADDR_RECV;
            end
            S_RXACK: begin
                w_bus_wr    = 1'b1;
                w_bus_wdata = 32'h2;
            end
            S_SEND: begin
                // TX head is stable here: only SEND pops, and pushes land behind the head.
                w_bus_wr    = 1'b1;
                w_bus_addr  = ADDR_SEND;
                w_bus_wdata = {24'h0, r_tx_mem[r_tx_rd]};
            end
            default: begin
                w_bus_rd = 1'b0;
            end
        endcase
    end

    // Registered uart_top bus port.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            uart_rd    <= 1'b0;
            uart_wr    <= 1'b0;
            uart_addr  <= ADDR_STATUS;
            uart_wdata <= 32'h0;
        end else begin
            uart_rd    <= w_bus_rd;
            uart_wr    <= w_bus_wr;
            uart_addr  <= w_bus_addr;
            uart_wdata <= w_bus_wdata;
        end
    end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Bench for uart_bus_sequencer: a stub uart_top (forced STATUS or byte loopback),
// a bus monitor with TX/RX scoreboards, and a directed stimulus sequence.
module tb_uart_bus_sequencer;

    localparam int PSW = 8;

    logic        clk_bus = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
    logic [3:0]  tx_level;
    logic [3:0]  rx_level;
    logic        busy;
    logic [3:0]  uart_addr;
    logic [31:0] uart_wdata;
    logic        uart_rd;
    logic        uart_wr;
    logic [31:0] uart_rdata;

    always #5 clk_bus = ~clk_bus;

    uart_bus_sequencer #(
        .TX_DEPTH(8), .RX_DEPTH(8), .POST_SEND_WAIT(PSW), .RX_ACK_WRITE(1)
    ) dut (
        .clk_bus(clk_bus), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_rd(uart_rd), .uart_wr(uart_wr), .uart_rdata(uart_rdata)
    );

    // ---------------- stub uart_top ----------------
    bit          loopback = 1'b0;
    logic [31:0] stub_status = 32'h0;
    logic [7:0]  stub_byte = 8'h30;
    logic [7:0]  lb_mem [16];
    int          lb_wr = 0;
    int          lb_rd = 0;

    always_comb begin
        uart_rdata = 32'h0;
        if (uart_rd) begin
            if (uart_addr == 4'hC)
                uart_rdata = loopback ? {30'h0, (lb_wr != lb_rd), 1'b1} : stub_status;
            else if (uart_addr == 4'h4)
                uart_rdata = loopback ? {24'h0, lb_mem[lb_rd[3:0]]} : {24'h0, stub_byte};
        end
    end

    always @(posedge clk_bus) begin
        if (rst_n) begin
            if (loopback && uart_wr && uart_addr == 4'h8) begin
                lb_mem[lb_wr[3:0]] <= uart_wdata[7:0];
                lb_wr <= lb_wr + 1;
            end
            if (uart_rd && uart_addr == 4'h4) begin
                if (loopback) lb_rd <= lb_rd + 1;
                else          stub_byte <= stub_byte + 8'h07;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  tx_exp [$];
    logic [7:0]  rx_exp [$];
    int          recv_cnt = 0;
    int          send_cnt = 0;
    int          rx_pops = 0;
    int          send_recv_snap = 0;
    logic [3:0]  log_addr [64];
    bit          log_wr [64];
    logic [31:0] log_data [64];
    int          log_n = 0;
    bit          prev_poll_s0 = 1'b0;
    bit          after_send = 1'b0;
    int          idle_cnt = 0;

    always @(negedge clk_bus) begin
        if (!rst_n) begin
            after_send   = 1'b0;
            prev_poll_s0 = 1'b0;
        end else begin
            if (uart_rd || uart_wr) begin
                if (after_send) begin
                    check("post_send_idle", idle_cnt, PSW);
                    after_send = 1'b0;
                end
                if (log_n < 64) begin
                    log_addr[log_n] = uart_addr;
                    log_wr[log_n]   = uart_wr;
                    log_data[log_n] = uart_wr ? uart_wdata : uart_rdata;
                    log_n++;
                end
            end else if (after_send) begin
                idle_cnt++;
            end
            if (uart_wr && uart_addr == 4'h8) begin
                check("send_after_poll_s0", 32'(prev_poll_s0), 32'd1);
                check("send_expected", 32'(tx_exp.size() != 0), 32'd1);
                if (tx_exp.size() != 0) check("send_data", uart_wdata, {24'h0, tx_exp.pop_front()});
                send_cnt++;
                send_recv_snap = recv_cnt;
                after_send = 1'b1;
                idle_cnt = 0;
            end
            if (uart_rd && uart_addr == 4'h4) begin
                recv_cnt++;
                if (!loopback) rx_exp.push_back(uart_rdata[7:0]);
            end
            prev_poll_s0 = uart_rd && (uart_addr == 4'hC) && uart_rdata[0];
            if (rx_valid && rx_ready) begin
                check("rx_expected", 32'(rx_exp.size() != 0), 32'd1);
                if (rx_exp.size() != 0) check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
                rx_pops++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pat [9];
    int base_recv;
    int base_send;

    initial begin
        pat = '{8'hAA, 8'h00, 8'h55, 8'hFF, 8'h01, 8'h80, 8'h92, 8'hA7, 8'hEE};

        // Reset held 3 cycles with a push attempt.
        rst_n = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'h11;
        repeat (3) begin
            @(negedge clk_bus);
            check("rst_tx_level", 32'(tx_level), 32'd0);
            check("rst_rx_valid", 32'(rx_valid), 32'd0);
            check("rst_rd", 32'(uart_rd), 32'd0);
            check("rst_wr", 32'(uart_wr), 32'd0);
            check("rst_addr", 32'(uart_addr), 32'hC);
        end
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_wdata", uart_wdata, 32'd0);
        @(posedge clk_bus); #1;
        rst_n = 1'b1;
        tx_valid = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk_bus);
                if (uart_rd && uart_addr == 4'hC) seen = 1'b1;
            end
            check("poll_after_reset", 32'(seen), 32'd1);
        end

        // TX full: 9 back-to-back pushes with STATUS=0.
        stub_status = 32'h0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk_bus); #1;
            check("tx_ready_before_push", 32'(tx_ready), 32'(i < 8));
            tx_valid = 1'b1;
            tx_data = pat[i];
            if (i < 8) begin
                tx_exp.push_back(pat[i]);
                rx_exp.push_back(pat[i]);
            end
        end
        @(posedge clk_bus); #1;
        tx_valid = 1'b0;
        @(negedge clk_bus);
        check("txfull_level", 32'(tx_level), 32'd8);
        check("txfull_ready", 32'(tx_ready), 32'd0);
        check("txfull_no_send", send_cnt, 0);

        // Loopback: queued bytes go out and come back in order.
        @(posedge clk_bus); #1;
        loopback = 1'b1;
        rx_ready = 1'b1;
        for (int k = 0; k < 2000 && rx_pops < 8; k++) @(negedge clk_bus);
        check("lb_pops", rx_pops, 8);
        repeat (20) @(negedge clk_bus);
        check("lb_tx_level", 32'(tx_level), 32'd0);
        check("lb_rx_level", 32'(rx_level), 32'd0);
        check("lb_send_cnt", send_cnt, 8);
        check("lb_rx_sb_empty", rx_exp.size(), 0);

        // Priority: STATUS=3 with one TX byte; RX fills first, RXACK between.
        @(posedge clk_bus); #1;
        loopback = 1'b0;
        rx_ready = 1'b0;
        stub_status = 32'h0;
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        tx_exp.push_back(8'h3C);
        @(posedge clk_bus); #1;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk_bus);
        #1;
        base_recv = recv_cnt;
        base_send = send_cnt;
        log_n = 0;
        stub_status = 32'h3;
        for (int k = 0; k < 20 && log_n < 3; k++) @(negedge clk_bus);
        check("prio_log0_poll", {log_wr[0], log_addr[0], log_data[0][3:0]}, {1'b0, 4'hC, 4'h3});
        check("prio_log1_recv", {log_wr[1], log_addr[1]}, {1'b0, 4'h4});
        check("prio_log2_ack", {log_wr[2], log_addr[2], log_data[2][3:0]}, {1'b1, 4'hC, 4'h2});

        // RX full: 8 RECVs, then the SEND, then quiet.
        for (int k = 0; k < 200 && rx_level != 4'd8; k++) @(negedge clk_bus);
        check("rxfull_level", 32'(rx_level), 32'd8);
        for (int k = 0; k < 100 && send_cnt == base_send; k++) @(negedge clk_bus);
        check("prio_recv_before_send", send_recv_snap - base_recv, 8);
        repeat (20) @(negedge clk_bus);
        check("rxfull_recv_cnt", recv_cnt - base_recv, 8);
        check("rxfull_send_cnt", send_cnt - base_send, 1);
        check("rxfull_idle", 32'(busy), 32'd0);
        check("rxfull_level_hold", 32'(rx_level), 32'd8);
        @(posedge clk_bus); #1;
        rx_ready = 1'b1;
        @(posedge clk_bus); #1;
        rx_ready = 1'b0;
        for (int k = 0; k < 50 && (recv_cnt - base_recv) < 9; k++) @(negedge clk_bus);
        check("rxfull_recv_after_pop", recv_cnt - base_recv, 9);
        @(posedge clk_bus); #1;
        stub_status = 32'h0;
        rx_ready = 1'b1;
        for (int k = 0; k < 50 && rx_level != 4'd0; k++) @(negedge clk_bus);
        @(posedge clk_bus); #1;
        rx_ready = 1'b0;
        check("drain_rx_valid", 32'(rx_valid), 32'd0);
        check("drain_sb_empty", rx_exp.size(), 0);

        // Reset during WAIT after SEND of 0x5A with 3 bytes behind it.
        tx_valid = 1'b1;
        foreach (pat[i]) begin
            if (i < 4) begin
                tx_data = (i == 0) ? 8'h5A : (8'hB0 + 8'(i));
                tx_exp.push_back(tx_data);
                @(posedge clk_bus); #1;
            end
        end
        tx_valid = 1'b0;
        base_send = send_cnt;
        stub_status = 32'h1;
        for (int k = 0; k < 50 && send_cnt == base_send; k++) @(negedge clk_bus);
        check("wait_send_seen", send_cnt - base_send, 1);
        @(posedge clk_bus); #1;
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_bus_quiet", {31'h0, uart_rd | uart_wr}, 32'd0);
        check("wait_tx_level", 32'(tx_level), 32'd3);
        rst_n = 1'b0;
        @(posedge clk_bus); #1;
        rst_n = 1'b1;
        tx_exp.delete();
        check("wait_rst_tx_level", 32'(tx_level), 32'd0);
        check("wait_rst_wr", 32'(uart_wr), 32'd0);
        check("wait_rst_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk_bus);
        check("wait_rst_no_send", send_cnt - base_send, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_sequencer.md
Name: uart_bus_sequencer

Overview:
- Autonomous bus master that owns the uart_top register port (RECV 0x4, SEND 0x8, STATUS 0xC) on the clk_bus domain.
- Buffers outbound bytes in a TX FIFO and inbound bytes in an RX FIFO.
- Polls STATUS, writes SEND when the transmitter is ready, and reads RECV when a byte is available.
- Frees the CPU from polling loops; sits between the peripheral interconnect and uart_top.

Parameters:
- TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
- RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
- POST_SEND_WAIT, 8, clk_bus cycles to hold off after a SEND write before re-polling (covers the status CDC lag)
- RX_ACK_WRITE, 1, 1 = after each RECV read, write 32'h2 to STATUS to clear the rx-available flag

Ports:
- clk_bus  in  1  bus clock; only clock
- rst_n  in  1  synchronous active-low reset
- tx_valid  in  1  host push strobe
- tx_data  in  8  byte to transmit
- tx_ready  out  1  TX FIFO not full
- rx_valid  out  1  RX FIFO not empty
- rx_data  out  8  head of RX FIFO (first-word fall-through)
- rx_ready  in  1  host pop strobe
- tx_level  out  $clog2(TX_DEPTH)+1  TX occupancy
- rx_level  out  $clog2(RX_DEPTH)+1  RX occupancy
- busy  out  1  state != IDLE
- uart_addr  out  4  to uart_top bus_address
- uart_wdata  out  32  to uart_top bus_data_i
- uart_rd  out  1  to uart_top bus_read
- uart_wr  out  1  to uart_top bus_write
- uart_rdata  in  32  from uart_top bus_data_o; combinational, valid in the same cycle as uart_rd

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE; both FIFOs empty; levels 0.
  - tx_ready=1, rx_valid=0, rx_data=0, busy=0.
  - uart_rd=0, uart_wr=0, uart_addr=4'hC, uart_wdata=0.
  - Reset mid-operation discards FIFO contents and any in-flight bus access; the uart_top transaction is simply not issued.
- Bus outputs are registered and reflect the current state; exactly one of uart_rd/uart_wr is high in POLL/RECV/SEND/RXACK, and neither is high otherwise. uart_rdata is sampled at the posedge ending a read cycle.
- FIFOs:
  - Push when tx_valid&&tx_ready; pop when rx_valid&&rx_ready.
  - Push while full is ignored (no overwrite). Pop while empty is ignored.
  - Simultaneous push and pop is legal at any level: level unchanged, pointers wrap modulo depth.
- FSM states:
  - IDLE:
    - -> POLL when TX non-empty or RX not full.
    - Stays IDLE when TX empty and RX full.
  - POLL: uart_rd=1, addr=0xC, one cycle. At the edge, with s=uart_rdata, the next state is chosen in priority order:
    - RECV if s[1] and RX not full (RX has priority over TX).
    - SEND if s[0] and TX non-empty.
    - IDLE otherwise.
  - RECV: uart_rd=1, addr=0x4, one cycle; uart_rdata[7:0] is pushed into RX at the edge.
    - -> RXACK if RX_ACK_WRITE, else POLL.
  - RXACK: uart_wr=1, addr=0xC, wdata=32'h2, one cycle -> POLL.
  - SEND: uart_wr=1, addr=0x8, wdata={24'b0, TX head}, one cycle; TX pops at the same edge -> WAIT.
  - WAIT: bus idle; counts POST_SEND_WAIT cycles -> POLL. POST_SEND_WAIT=0 goes straight to POLL.
- No SEND without a preceding POLL that saw s[0]=1. This guarantees one write per tx-ready indication.
- Internal RX push and host pop in the same cycle follow the simultaneous push/pop rule above.
- Latency, first byte, from an empty idle state:
  - push at edge N; POLL in cycle N+1; SEND in cycle N+2 if s[0]=1.
- busy=1 in every state except IDLE.

Test Plan:
- Reset: hold rst_n low 3 cycles with tx_valid=1 -> tx_level=0, rx_valid=0, uart_rd=uart_wr=0, uart_addr=4'hC; after release, POLL reads are seen.
- Loopback with real uart_top (txd->rxd): push AA,00,55,FF,01,80,92,A7 -> rx_data pops the same 8 bytes in order; each SEND is preceded by a STATUS read with bit0=1 and followed by >=POST_SEND_WAIT idle cycles.
- Priority: stub uart_top returns STATUS=32'h3, TX holds 1 byte -> RECV (addr 4) issued before SEND (addr 8); with RX_ACK_WRITE=1, a write of 32'h2 to addr C sits between them.
- RX full: RX_DEPTH=8, stub STATUS=32'h2, no host pops -> exactly 8 RECV reads, rx_level=8; then only SENDs/IDLE, and no RECV until one pop occurs.
- TX full: push 9 bytes back-to-back with STATUS=0 -> tx_ready falls after the 8th, the 9th byte is dropped, tx_level=8.
- Reset during WAIT after a SEND of 0x5A with 3 bytes queued -> tx_level=0 next cycle, no further SEND write issued.
